// File: rtl/lsu_pkg.sv
// Shared LSU-port definitions: widths and the arbiter ownership encoding.
package lsu_pkg;

  localparam int unsigned AddrW = 12;
  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = 4;

  // Which master currently holds the LSU port across consecutive grants.
  typedef enum logic [1:0] {
    OwnerNone = 2'd0,
    OwnerM0   = 2'd1,
    OwnerM1   = 2'd2
  } owner_e;

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-master grant decision with owner stickiness and a burst cap.
module rr_grant2
  import lsu_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [1:0] owner_i,
  input  logic       cap_i,   // owner has used up its burst allowance
  input  logic       last_i,  // 1 = master 1 was granted most recently
  output logic [1:0] gnt_o
);

  // Sole requester always wins; ties go to the owner until capped, else away from last.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      2'b11: begin
        if (owner_i == OwnerM0) begin
          gnt_o = cap_i ? 2'b10 : 2'b01;
        end else if (owner_i == OwnerM1) begin
          gnt_o = cap_i ? 2'b01 : 2'b10;
        end else begin
          gnt_o = last_i ? 2'b01 : 2'b10;
        end
      end
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares the LSU data port between the core (master 0) and a debug/DMA master (master 1).
module lsu_arbiter
  import lsu_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [11:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_be_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [11:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_be_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        lsu_st_en_o,
  output logic [11:0] lsu_addr_o,
  output logic [31:0] lsu_st_data_o,
  output logic [3:0]  lsu_byte_en_o,
  input  logic [31:0] lsu_ld_data_i
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  owner_e          owner_q, owner_d;
  logic [CntW-1:0] burst_q, burst_d;
  logic            last_q, last_d;
  logic [1:0]      gnt;
  logic            cap;
  logic            ld0, ld1;
  logic            rvalid0_q, rvalid1_q;
  logic [31:0]     rdata0_q, rdata1_q;

  assign cap = (burst_q == CntW'(MAX_BURST));

  rr_grant2 u_rr_grant2 (
    .req_i   ({m1_req_i, m0_req_i}),
    .owner_i (owner_q),
    .cap_i   (cap),
    .last_i  (last_q),
    .gnt_o   (gnt)
  );

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  // Ownership and burst counting; any idle cycle releases ownership.
  always_comb begin
    owner_d = OwnerNone;
    burst_d = '0;
    last_d  = last_q;
    if (gnt != 2'b00) begin
      owner_d = gnt[1] ? OwnerM1 : OwnerM0;
      last_d  = gnt[1];
      if (owner_d == owner_q) begin
        burst_d = cap ? burst_q : burst_q + 1'b1;
      end else begin
        burst_d = CntW'(1);
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q <= OwnerNone;
      burst_q <= '0;
      last_q  <= 1'b1;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  // LSU drive from the granted master; all-zero when idle so no stray store.
  always_comb begin
    lsu_st_en_o   = 1'b0;
    lsu_addr_o    = '0;
    lsu_st_data_o = '0;
    lsu_byte_en_o = '0;
    if (gnt[0]) begin
      lsu_st_en_o   = m0_we_i;
      lsu_addr_o    = m0_addr_i;
      lsu_st_data_o = m0_wdata_i;
      lsu_byte_en_o = m0_be_i;
    end else if (gnt[1]) begin
      lsu_st_en_o   = m1_we_i;
      lsu_addr_o    = m1_addr_i;
      lsu_st_data_o = m1_wdata_i;
      lsu_byte_en_o = m1_be_i;
    end
  end

  assign ld0 = gnt[0] & ~m0_we_i;
  assign ld1 = gnt[1] & ~m1_we_i;

  // Load responses: one-cycle rvalid pulse, rdata held between loads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= ld0;
      rvalid1_q <= ld1;
      if (ld0) rdata0_q <= lsu_ld_data_i;
      if (ld1) rdata1_q <= lsu_ld_data_i;
    end
  end

  assign m0_rvalid_o = rvalid0_q;
  assign m0_rdata_o  = rdata0_q;
  assign m1_rvalid_o = rvalid1_q;
  assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Randomised and directed checks of lsu_arbiter against a behavioural arbitration model.
module tb_lsu_arbiter;

  localparam int MaxBurst = 4;

  logic        clk;
  logic        rst_ni;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [11:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        lsu_st_en;
  logic [11:0] lsu_addr;
  logic [31:0] lsu_st_data;
  logic [3:0]  lsu_byte_en;
  logic [31:0] lsu_ld_data;

  lsu_arbiter #(.MAX_BURST(MaxBurst)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .m0_req_i      (m0_req),
    .m0_we_i       (m0_we),
    .m0_addr_i     (m0_addr),
    .m0_wdata_i    (m0_wdata),
    .m0_be_i       (m0_be),
    .m0_gnt_o      (m0_gnt),
    .m0_rvalid_o   (m0_rvalid),
    .m0_rdata_o    (m0_rdata),
    .m1_req_i      (m1_req),
    .m1_we_i       (m1_we),
    .m1_addr_i     (m1_addr),
    .m1_wdata_i    (m1_wdata),
    .m1_be_i       (m1_be),
    .m1_gnt_o      (m1_gnt),
    .m1_rvalid_o   (m1_rvalid),
    .m1_rdata_o    (m1_rdata),
    .lsu_st_en_o   (lsu_st_en),
    .lsu_addr_o    (lsu_addr),
    .lsu_st_data_o (lsu_st_data),
    .lsu_byte_en_o (lsu_byte_en),
    .lsu_ld_data_i (lsu_ld_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_val(int a);
    return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // LSU stand-in: combinational read, byte-enabled write on the clock edge.
  logic [31:0] mem [0:4095];
  assign lsu_ld_data = mem[lsu_addr];
  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = init_val(a);
    mem[12'h815] = 32'h89AB_CDEF;
    forever begin
      @(posedge clk);
      if (rst_ni && lsu_st_en) begin
        for (int b = 0; b < 4; b++) begin
          if (lsu_byte_en[b]) mem[lsu_addr][b*8 +: 8] = lsu_st_data[b*8 +: 8];
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int exp_g  = 0;   // model's grant this cycle: 0 none, 1 = M0, 2 = M1

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer owner/count/last, its own memory image, expected responses.
  initial begin : compare
    int          own, cnt, lst, g;
    bit          exp_rv [2];
    logic [31:0] exp_rd [2];
    logic [31:0] ref_mem [4096];
    logic        rq [2];
    logic        wr [2];
    logic [11:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    logic [11:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic        e_st;
    for (int a = 0; a < 4096; a++) ref_mem[a] = init_val(a);
    ref_mem[12'h815] = 32'h89AB_CDEF;
    own = 0; cnt = 0; lst = 2;
    exp_rv[0] = 0; exp_rv[1] = 0; exp_rd[0] = '0; exp_rd[1] = '0;
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        if (!rst_ni) begin
          own = 0; cnt = 0; lst = 2;
          exp_rv[0] = 0; exp_rv[1] = 0; exp_rd[0] = '0; exp_rd[1] = '0;
        end
        rq[0] = m0_req; wr[0] = m0_we; ad[0] = m0_addr; wd[0] = m0_wdata; be[0] = m0_be;
        rq[1] = m1_req; wr[1] = m1_we; ad[1] = m1_addr; wd[1] = m1_wdata; be[1] = m1_be;
        if (!rq[0] && !rq[1]) g = 0;
        else if (rq[0] != rq[1]) g = rq[0] ? 1 : 2;
        else if (own != 0) g = (cnt >= MaxBurst) ? 3 - own : own;
        else g = 3 - lst;
        exp_g = g;
        e_st = 0; e_addr = '0; e_data = '0; e_be = '0;
        if (g != 0) begin
          e_st = wr[g-1]; e_addr = ad[g-1]; e_data = wd[g-1]; e_be = be[g-1];
        end
        chk("m0_gnt", 32'(m0_gnt), 32'(g == 1));
        chk("m1_gnt", 32'(m1_gnt), 32'(g == 2));
        chk("gnt_mutex", 32'(m0_gnt & m1_gnt), 32'd0);
        chk("lsu_st_en", 32'(lsu_st_en), 32'(e_st));
        chk("lsu_addr", 32'(lsu_addr), 32'(e_addr));
        chk("lsu_st_data", lsu_st_data, e_data);
        chk("lsu_byte_en", 32'(lsu_byte_en), 32'(e_be));
        chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0]));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1]));
        chk("m0_rdata", m0_rdata, exp_rd[0]);
        chk("m1_rdata", m1_rdata, exp_rd[1]);
        if (rst_ni) begin
          exp_rv[0] = 0; exp_rv[1] = 0;
          if (g != 0) begin
            cnt = (g == own) ? ((cnt < MaxBurst) ? cnt + 1 : cnt) : 1;
            own = g;
            lst = g;
            if (wr[g-1]) begin
              for (int b = 0; b < 4; b++) begin
                if (be[g-1][b]) ref_mem[ad[g-1]][b*8 +: 8] = wd[g-1][b*8 +: 8];
              end
            end else begin
              exp_rv[g-1] = 1;
              exp_rd[g-1] = ref_mem[ad[g-1]];
            end
          end else begin
            own = 0;
            cnt = 0;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
  endtask

  initial begin : stim
    rst_ni = 1'b0;
    idle();
    repeat (2) cyc();
    #3;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_lsu", 32'({lsu_st_en, lsu_byte_en}) | 32'(lsu_addr) | lsu_st_data, 32'd0);
    cyc();
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // M0 store then load of the same word.
    cyc();
    m0_req = 1; m0_we = 1; m0_addr = 12'h752; m0_wdata = 32'h1357_9BDF; m0_be = 4'hF;
    #3 chk("t1_st_gnt", 32'(m0_gnt), 32'd1);
    chk("t1_st_en", 32'(lsu_st_en), 32'd1);
    cyc();
    m0_we = 0;
    #3 chk("t1_ld_gnt", 32'(m0_gnt), 32'd1);
    cyc();
    m0_req = 0;
    #3 chk("t1_rvalid", 32'(m0_rvalid), 32'd1);
    chk("t1_rdata", m0_rdata, 32'h1357_9BDF);
    chk("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);

    // Both request straight out of reset: M0 x4, M1 x4, M0 x4.
    cyc(); rst_ni = 0;
    cyc(); rst_ni = 1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      m0_req = 1; m0_addr = 12'h010; m1_req = 1; m1_addr = 12'h020;
      #3 chk("t2_m0_gnt", 32'(m0_gnt), 32'(((i / 4) % 2) == 0));
      chk("t2_m1_gnt", 32'(m1_gnt), 32'(((i / 4) % 2) == 1));
    end

    // Owner drops request while peer raises it: peer granted the same cycle.
    cyc(); m1_req = 0;
    cyc();
    m0_req = 0; m1_req = 1;
    #3 chk("t3_m1_gnt", 32'(m1_gnt), 32'd1);

    // Alternating M1 stores and M0 loads.
    for (int k = 0; k < 4; k++) begin
      cyc();
      idle();
      if (k % 2 == 0) begin
        m1_req = 1; m1_we = 1; m1_addr = 12'h800; m1_wdata = 32'h0123_4567; m1_be = 4'hF;
        #3 chk("t4_st_addr", 32'(lsu_addr), 32'h800);
        chk("t4_st_en", 32'(lsu_st_en), 32'd1);
        if (k > 0) chk("t4_m0_rdata", m0_rdata, 32'h89AB_CDEF);
      end else begin
        m0_req = 1; m0_addr = 12'h815;
        #3 chk("t4_ld_addr", 32'(lsu_addr), 32'h815);
        chk("t4_ld_st_en", 32'(lsu_st_en), 32'd0);
      end
    end

    // Idle: LSU outputs stay zero, memory untouched.
    cyc(); idle();
    for (int i = 0; i < 10; i++) begin
      #3 chk("t5_lsu_idle", 32'({lsu_st_en, lsu_byte_en}) | 32'(lsu_addr) | lsu_st_data, 32'd0);
      cyc();
    end
    chk("t5_mem_752", mem[12'h752], 32'h1357_9BDF);
    chk("t5_mem_800", mem[12'h800], 32'h0123_4567);

    // Reset during a granted load drops the response.
    m0_req = 1; m0_addr = 12'h815;
    #3 rst_ni = 0;
    cyc(); idle();
    #3 chk("t6_rvalid", 32'(m0_rvalid), 32'd0);
    chk("t6_rdata", m0_rdata, 32'd0);
    cyc(); rst_ni = 1;
    #3 chk("t6_post_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    cyc();
    m0_req = 1; m1_req = 1;
    #3 chk("t6_tie_m0", 32'(m0_gnt), 32'd1);

    // Random traffic; an ungranted request is held unchanged.
    for (int n = 0; n < 2000; n++) begin
      cyc();
      if (!(m0_req && exp_g != 1)) begin
        m0_req = ($urandom_range(0, 9) < 6); m0_we = $urandom_range(0, 1);
        m0_addr = 12'($urandom_range(0, 31)); m0_wdata = $urandom(); m0_be = 4'($urandom());
      end
      if (!(m1_req && exp_g != 2)) begin
        m1_req = ($urandom_range(0, 9) < 6); m1_we = $urandom_range(0, 1);
        m1_addr = 12'($urandom_range(0, 31)); m1_wdata = $urandom(); m1_be = 4'($urandom());
      end
    end

    cyc(); idle();
    cyc();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-port arbiter sharing the single LSU data port between the core (master 0) and a debug/DMA requester (master 1). It sits between the requesters and the LSU, drives the LSU address, store-data, byte-enable and store-enable inputs from whichever master holds the grant, and returns a registered load response to that master. Arbitration uses a round-robin owner scheme with a burst cap, so neither master can starve the other.

## Interface
- `MAX_BURST`, default 4: consecutive grants an owner may take while the other master is requesting (must be ≥1).
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `m0_req_i`  in  1  master 0 request, held until granted.
- `m0_we_i`  in  1  1 = store, 0 = load.
- `m0_addr_i`  in  12  LSU address.
- `m0_wdata_i`  in  32  store data.
- `m0_be_i`  in  4  byte enables.
- `m0_gnt_o`  out  1  grant; combinational, transfer occurs on an edge where req & gnt.
- `m0_rvalid_o`  out  1  load response valid, one cycle after a granted load.
- `m0_rdata_o`  out  32  load response data.
- `m1_*`: same set for master 1.
- `lsu_st_en_o`  out  1  to LSU `st_en`.
- `lsu_addr_o`  out  12  to LSU `addr`.
- `lsu_st_data_o`  out  32  to LSU `st_data`.
- `lsu_byte_en_o`  out  4  to LSU `byte_en`.
- `lsu_ld_data_i`  in  32  from LSU `ld_data`, combinational with address.

## Operation
- State: `owner` ∈ {NONE, M0, M1}, `burst_cnt` (0..MAX_BURST, saturating), `last` (1 bit, last granted master).
- Grant decision, each cycle, combinational:
  - If only one master requests, grant it, except when owner == that master's peer... no exception: a sole requester is always granted.
  - If both request, owner == Mx and burst_cnt < MAX_BURST: grant Mx.
  - If both request, owner == Mx and burst_cnt == MAX_BURST: grant the other.
  - If both request and owner == NONE: grant the master ≠ `last`.
  - If no master requests: no grant.
- Update on the edge:
  - On a grant to Mg, set owner = Mg and last = Mg. burst_cnt becomes min(burst_cnt+1, MAX_BURST) if Mg equals the previous owner, else 1.
  - With no grant, set owner = NONE and burst_cnt = 0; `last` is held.
- LSU drive:
  - With a grant, addr, st_data and byte_en come from the granted master; `lsu_st_en_o` = granted master's we.
  - With no grant, all LSU outputs are 0, so no store can occur.
- Response:
  - On an edge with a granted load, capture `lsu_ld_data_i` into that master's rdata register and pulse its rvalid for exactly one cycle.
  - Stores produce no rvalid; rdata holds its last value.
- At most one grant per cycle; m0_gnt_o & m1_gnt_o is never 1.

## Timing
- Reset values:
  - owner = NONE, burst_cnt = 0, last = M1, so M0 wins the first tie.
  - All gnt, rvalid and LSU outputs are 0; both rdata = 0.
- Store latency: written into the LSU on the granting edge.
- Load latency: 1 cycle (grant cycle, then rvalid cycle). Back-to-back loads give rvalid on consecutive cycles.
- A master dropping req while owner lets the peer win in the same cycle; there are no idle bubbles.
- Simultaneous first requests resolve via `last`.
- Burst cap boundary: with MAX_BURST = 4 and both masters requesting continuously, the pattern is four M0 grants, then four M1 grants, and so on.
- Reset asserted mid-operation clears all state asynchronously. Any pending rvalid is dropped and not re-issued.

## Structure
- Shared package `lsu_pkg`: `owner_e` enum (NONE, M0, M1), LSU address width 12, data width 32, byte-enable width 4.
- One natural sub-module, `rr_grant2`: a combinational two-input arbiter taking req[1:0], owner, burst-cap flag and last, and returning gnt[1:0].
- The top level holds the state registers, the LSU mux and the response registers.

## Test plan
- Reset, then M0 store to 0x752 with data 0x13579BDF and be = 1111, then an M0 load from 0x752 → m0_gnt = 1 each cycle; m0_rvalid = 1 one cycle after the load with m0_rdata = 0x13579BDF; m1_rvalid stays 0.
- Both masters request from reset, in the same cycle, with MAX_BURST = 4 → grant sequence M0×4, M1×4, M0×4; never both grants asserted.
- M0 bursting, M0 drops req, M1 requests in the same cycle → M1 is granted that cycle, with no empty cycle.
- M1 stores 0x01234567 to 0x800 while M0 loads 0x815 in alternation → the LSU sees the correct muxed address, st_en = 1 only on M1 grant cycles; M0 reads back 0x89ABCDEF.
- No requests → all LSU outputs 0 for 10 cycles; LSU contents unchanged.
- Assert rst_ni low on a cycle with a granted load → rvalid stays 0; after release, outputs are back at reset values and M0 wins the next tie.
